mips_divider: RTL and testbench

Multi-cycle restoring integer divider for the MIPS datapath; it implements DIV and DIVU. It is the inverse counterpart to the adder and multiplier arithmetic: each iteration performs one shift-and-subtract step on an adder-based subtractor. Results are written to the HI/LO pair, with QUOTIENT going to LO and REMAINDER to HI. The control unit starts an operation with a START pulse and stalls on BUSY until DONE.

---
 rtl/mips_divider.sv | 189 ++++++++++++++++++
 tb/tb_mips_divider.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_divider.sv
// mips_divider
// ------------
// Multi-cycle restoring integer divider for the MIPS HI/LO unit (DIV / DIVU).
// One shift-and-subtract step per clock on an adder-based subtractor.
//
// Ports:
//   CLK          clock, all state changes on the rising edge
//   RESET        synchronous active-high reset, highest priority
//   START        request a division, honoured only while idle
//   SIGNED       1 = DIV (two's complement), 0 = DIVU, sampled with START
//   DIVIDEND     numerator (rs), sampled with START
//   DIVISOR      denominator (rt), sampled with START
//   QUOTIENT     result to LO, updated only when DONE is raised
//   REMAINDER    result to HI, updated only when DONE is raised
//   BUSY         high while an operation is in progress
//   DONE         one-cycle pulse when QUOTIENT/REMAINDER are valid
//   DIV_BY_ZERO  raised with DONE for a zero divisor, held until next START
module mips_divider #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             SIGNED,
  input  logic [WIDTH-1:0] DIVIDEND,
  input  logic [WIDTH-1:0] DIVISOR,
  output logic [WIDTH-1:0] QUOTIENT,
  output logic [WIDTH-1:0] REMAINDER,
  output logic             BUSY,
  output logic             DONE,
  output logic             DIV_BY_ZERO
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FIXUP = 2'd2
  } state_t;

  // Two's complement negation.
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    negate = ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Magnitude of an operand; the most-negative value maps to 2^(WIDTH-1)
  // read as unsigned, so it needs no special handling.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic             sgn);
    if (sgn && x[WIDTH-1]) begin
      magnitude = negate(x);
    end else begin
      magnitude = x;
    end
  endfunction

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic             sgn_r;
  logic             a_neg_r;
  logic             b_neg_r;
  logic [WIDTH-1:0] q_r;       // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] rem_r;     // partial remainder
  logic [WIDTH-1:0] d_r;       // divisor magnitude

  logic [WIDTH:0]   r_shift_s;
  logic [WIDTH-1:0] diff_s;
  logic             carry_s;
  logic             ge_s;
  logic [WIDTH-1:0] rem_next_s;
  logic [WIDTH-1:0] q_next_s;
  logic [WIDTH-1:0] quot_fix_s;
  logic [WIDTH-1:0] rem_fix_s;
  logic             div_zero_s;

  // Datapath: one restoring step plus the final sign fix-up.
  always_comb begin
    r_shift_s = {rem_r, q_r[WIDTH-1]};
    // WIDTH-bit subtract on the low bits; a set top bit of the shifted
    // remainder already guarantees R' >= D, and the low-bit difference is
    // then the true result because the remainder always ends below D.
    {carry_s, diff_s} = {1'b0, r_shift_s[WIDTH-1:0]} + {1'b0, ~d_r}
                        + {{WIDTH{1'b0}}, 1'b1};
    ge_s = r_shift_s[WIDTH] | carry_s;
    if (ge_s) begin
      rem_next_s = diff_s;
    end else begin
      rem_next_s = r_shift_s[WIDTH-1:0];
    end
    q_next_s = {q_r[WIDTH-2:0], ge_s};

    // Quotient truncates toward zero, remainder follows the dividend sign.
    if (sgn_r && (a_neg_r != b_neg_r)) begin
      quot_fix_s = negate(q_r);
    end else begin
      quot_fix_s = q_r;
    end
    if (sgn_r && a_neg_r) begin
      rem_fix_s = negate(rem_r);
    end else begin
      rem_fix_s = rem_r;
    end

    div_zero_s = (DIVISOR == {WIDTH{1'b0}});
  end

  // Control FSM with registered result and handshake outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      sgn_r       <= 1'b0;
      a_neg_r     <= 1'b0;
      b_neg_r     <= 1'b0;
      q_r         <= {WIDTH{1'b0}};
      rem_r       <= {WIDTH{1'b0}};
      d_r         <= {WIDTH{1'b0}};
      QUOTIENT    <= {WIDTH{1'b0}};
      REMAINDER   <= {WIDTH{1'b0}};
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      DIV_BY_ZERO <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (START) begin
            sgn_r       <= SIGNED;
            a_neg_r     <= DIVIDEND[WIDTH-1];
            b_neg_r     <= DIVISOR[WIDTH-1];
            q_r         <= magnitude(DIVIDEND, SIGNED);
            d_r         <= magnitude(DIVISOR, SIGNED);
            rem_r       <= {WIDTH{1'b0}};
            cnt_r       <= {CW{1'b0}};
            DIV_BY_ZERO <= 1'b0;
            if (div_zero_s) begin
              // Zero divisor resolves immediately without iterating.
              state_r     <= IDLE;
              BUSY        <= 1'b0;
              DONE        <= 1'b1;
              DIV_BY_ZERO <= 1'b1;
              QUOTIENT    <= {WIDTH{1'b1}};
              REMAINDER   <= DIVIDEND;
            end else begin
              state_r <= ITER;
              BUSY    <= 1'b1;
              DONE    <= 1'b0;
            end
          end else begin
            state_r <= IDLE;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
          end
        end

        ITER: begin
          q_r   <= q_next_s;
          rem_r <= rem_next_s;
          DONE  <= 1'b0;
          BUSY  <= 1'b1;
          if (cnt_r == CW'(WIDTH - 1)) begin
            state_r <= FIXUP;
            cnt_r   <= {CW{1'b0}};
          end else begin
            state_r <= ITER;
            cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end

        FIXUP: begin
          QUOTIENT  <= quot_fix_s;
          REMAINDER <= rem_fix_s;
          BUSY      <= 1'b0;
          DONE      <= 1'b1;
          state_r   <= IDLE;
        end

        default: begin
          // Unreachable encoding: fall back to a quiet idle.
          state_r <= IDLE;
          cnt_r   <= {CW{1'b0}};
          BUSY    <= 1'b0;
          DONE    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_divider.sv
module tb_mips_divider;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         START;
  logic         SIGNED;
  logic [W-1:0] DIVIDEND;
  logic [W-1:0] DIVISOR;
  logic [W-1:0] QUOTIENT;
  logic [W-1:0] REMAINDER;
  logic         BUSY;
  logic         DONE;
  logic         DIV_BY_ZERO;

  int checks = 0;
  int errors = 0;

  mips_divider #(.WIDTH(W)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .SIGNED(SIGNED),
    .DIVIDEND(DIVIDEND), .DIVISOR(DIVISOR),
    .QUOTIENT(QUOTIENT), .REMAINDER(REMAINDER),
    .BUSY(BUSY), .DONE(DONE), .DIV_BY_ZERO(DIV_BY_ZERO)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive START for one edge from the current time, then scramble operands.
  task automatic issue_now(input logic sgn, input logic [W-1:0] a,
                           input logic [W-1:0] b);
    SIGNED   = sgn;
    DIVIDEND = a;
    DIVISOR  = b;
    START    = 1'b1;
    @(posedge CLK);
    #1;
    START    = 1'b0;
    SIGNED   = 1'($urandom_range(0, 1));
    DIVIDEND = $urandom;
    DIVISOR  = $urandom;
  endtask

  task automatic start_op(input logic sgn, input logic [W-1:0] a,
                          input logic [W-1:0] b);
    @(negedge CLK);
    issue_now(sgn, a, b);
  endtask

  // Called just after the START edge (edge 1). Counts edges until DONE is
  // seen and the number of sampled cycles with BUSY high. Optionally raises
  // a stray START after edge inject_at.
  task automatic wait_done(input int inject_at, output int edges,
                           output int busy_cnt);
    edges    = 1;
    busy_cnt = BUSY ? 1 : 0;
    while (!DONE && edges < 200) begin
      if (edges == inject_at) begin
        SIGNED   = 1'b1;
        DIVIDEND = 32'd9;
        DIVISOR  = 32'd3;
        START    = 1'b1;
      end
      @(posedge CLK);
      #1;
      START = 1'b0;
      edges++;
      if (BUSY) busy_cnt++;
    end
    if (!DONE) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no DONE after %0d edges, required DONE", edges);
    end
  endtask

  initial begin
    int e;
    int bc;
    int done_seen;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
    vecs[2]  = '{1'b0, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   32'd1,          1'b0};
    vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
    vecs[4]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
    vecs[5]  = '{1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1};
    vecs[6]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0};
    vecs[7]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   1'b0};
    vecs[8]  = '{1'b0, 32'hFFFFFFFF,   32'h80000001,   32'd1,          32'h7FFFFFFE,   1'b0};
    vecs[9]  = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3,          1'b0};
    vecs[10] = '{1'b1, 32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFF9,   1'b1};
    vecs[11] = '{1'b0, 32'h12345678,   32'h00001000,   32'h00012345,   32'h00000678,   1'b0};

    RESET    = 1'b1;
    START    = 1'b0;
    SIGNED   = 1'b0;
    DIVIDEND = 32'd0;
    DIVISOR  = 32'd0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_q",    QUOTIENT,    32'd0);
    check("rst_r",    REMAINDER,   32'd0);
    check("rst_busy", 32'(BUSY),   32'd0);
    check("rst_done", 32'(DONE),   32'd0);
    check("rst_dbz",  32'(DIV_BY_ZERO), 32'd0);
    RESET = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < 12; i++) begin
      start_op(vecs[i].sgn, vecs[i].a, vecs[i].b);
      wait_done(0, e, bc);
      check($sformatf("v%0d_latency", i), 32'(e),  vecs[i].dbz ? 32'd1 : 32'd34);
      check($sformatf("v%0d_busy", i),    32'(bc), vecs[i].dbz ? 32'd0 : 32'd33);
      check($sformatf("v%0d_q", i),   QUOTIENT,  vecs[i].q);
      check($sformatf("v%0d_r", i),   REMAINDER, vecs[i].r);
      check($sformatf("v%0d_dbz", i), 32'(DIV_BY_ZERO), 32'(vecs[i].dbz));
      @(posedge CLK);
      #1;
      check($sformatf("v%0d_done_pulse", i), 32'(DONE), 32'd0);
      check($sformatf("v%0d_q_hold", i), QUOTIENT, vecs[i].q);
      check($sformatf("v%0d_dbz_hold", i), 32'(DIV_BY_ZERO), 32'(vecs[i].dbz));
    end

    // Stray START mid-operation is ignored.
    start_op(1'b0, 32'd100, 32'd7);
    wait_done(10, e, bc);
    check("ign_latency", 32'(e), 32'd34);
    check("ign_q", QUOTIENT,  32'd14);
    check("ign_r", REMAINDER, 32'd2);

    // Reset at cycle 20 aborts the operation with no DONE.
    start_op(1'b0, 32'd1000, 32'd3);
    repeat (19) @(posedge CLK);
    #1;
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    check("mrst_q",    QUOTIENT,  32'd0);
    check("mrst_r",    REMAINDER, 32'd0);
    check("mrst_busy", 32'(BUSY), 32'd0);
    check("mrst_done", 32'(DONE), 32'd0);
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge CLK);
      #1;
      if (DONE) done_seen++;
    end
    check("mrst_no_done", 32'(done_seen), 32'd0);
    start_op(1'b0, 32'd100, 32'd7);
    wait_done(0, e, bc);
    check("post_rst_latency", 32'(e), 32'd34);
    check("post_rst_q", QUOTIENT,  32'd14);
    check("post_rst_r", REMAINDER, 32'd2);

    // DIV_BY_ZERO holds until the next accepted START, results hold meanwhile.
    start_op(1'b0, 32'd5, 32'd0);
    wait_done(0, e, bc);
    repeat (3) @(posedge CLK);
    #1;
    check("dbz_held", 32'(DIV_BY_ZERO), 32'd1);
    start_op(1'b0, 32'd100, 32'd7);
    check("dbz_cleared", 32'(DIV_BY_ZERO), 32'd0);
    check("dbz_busy",    32'(BUSY), 32'd1);
    check("dbz_q_hold",  QUOTIENT,  32'hFFFFFFFF);
    check("dbz_r_hold",  REMAINDER, 32'd5);
    wait_done(0, e, bc);
    check("after_dbz_q", QUOTIENT,  32'd14);
    check("after_dbz_r", REMAINDER, 32'd2);

    // Back-to-back: START in the DONE cycle is accepted.
    issue_now(1'b0, 32'd9, 32'd3);
    check("b2b_done_low", 32'(DONE), 32'd0);
    check("b2b_busy",     32'(BUSY), 32'd1);
    check("b2b_q_hold",   QUOTIENT,  32'd14);
    check("b2b_r_hold",   REMAINDER, 32'd2);
    wait_done(0, e, bc);
    check("b2b_latency", 32'(e), 32'd34);
    check("b2b_q", QUOTIENT,  32'd3);
    check("b2b_r", REMAINDER, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
